// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_ctrl
// Purpose  : Bit-serial ALU sequencer feeding an external 1-bit ALU slice,
//            LSB first. Zero flag built only with SERIAL_ALU_ZERO_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_add_sub,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_co,
  input  logic             slice_r
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_SLT = 3'b111;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic             r_legal;
  logic             r_cin0;
  logic             r_carry;
  logic [c_CW-1:0]  r_cnt;
  logic             r_cmsb;
  logic             r_cfin;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_op_legal;
  logic             w_drive;
  logic             w_cin;
  logic             w_msb_ovf;
  logic [WIDTH-1:0] w_final;
  logic             w_final_co;
  logic             w_final_ov;

  assign w_op_legal = (op == c_OP_AND) || (op == c_OP_OR) || (op == c_OP_ADD) ||
                      (op == c_OP_SUB) || (op == c_OP_SLT);

  // Slice is only driven while a legal op is shifting; idle/illegal gives zeros.
  assign w_drive       = (r_state == c_ST_SHIFT) && r_legal;
  assign w_cin         = (r_cnt == '0) ? r_cin0 : r_carry;
  assign slice_a       = w_drive & r_a[0];
  assign slice_b       = w_drive & r_b[0];
  assign slice_add_sub = w_drive & r_op[2];
  assign slice_op      = w_drive ? r_op[1:0] : 2'b00;
  assign slice_cin     = w_drive & w_cin;

  assign w_msb_ovf = r_cmsb ^ r_cfin;

  always_comb begin
    w_final    = '0;
    w_final_co = 1'b0;
    w_final_ov = 1'b0;
    if (r_legal) begin
      if (r_op == c_OP_SLT) begin
        w_final[0] = r_res[WIDTH-1] ^ w_msb_ovf;
      end else begin
        w_final = r_res;
        if (r_op[1:0] == 2'b10) begin
          w_final_co = r_cfin;
          w_final_ov = w_msb_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_op      <= 3'b000;
      r_legal   <= 1'b0;
      r_cin0    <= 1'b0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_cmsb    <= 1'b0;
      r_cfin    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_a     <= opa;
            r_b     <= opb;
            r_op    <= op;
            r_legal <= w_op_legal;
            r_cin0  <= (op == c_OP_ADD) ? carry_in : op[2];
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_ST_SHIFT;
          end
        end
        c_ST_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= {slice_r, r_res[WIDTH-1:1]};
          r_carry <= slice_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            // Carry into and out of the MSB give the signed overflow.
            r_cmsb  <= w_cin;
            r_cfin  <= slice_co;
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          r_done    <= 1'b1;
          r_result  <= w_final;
          r_cout    <= w_final_co;
          r_ovf     <= w_final_ov;
          r_illegal <= ~r_legal;
          r_state   <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic r_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (r_state == c_ST_DONE) begin
      r_zero <= (w_final == '0);
    end
  end
  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

  assign busy      = (r_state != c_ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_ctrl
// Purpose  : Self-checking bench for serial_alu_ctrl with a behavioural 1-bit
//            slice attached; honours SERIAL_ALU_ZERO_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         illegal;
  logic         zero;
  logic         slice_a;
  logic         slice_b;
  logic         slice_add_sub;
  logic         slice_cin;
  logic [1:0]   slice_op;
  logic         slice_co;
  logic         slice_r;

  int tests = 0;
  int fails = 0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .illegal(illegal), .zero(zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_add_sub(slice_add_sub),
    .slice_cin(slice_cin), .slice_op(slice_op), .slice_co(slice_co),
    .slice_r(slice_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 1-bit ALU slice: AND, OR, or full adder with optional B inversion.
  always_comb begin
    logic bx;
    bx       = slice_b ^ slice_add_sub;
    slice_r  = 1'b0;
    slice_co = 1'b0;
    case (slice_op)
      2'b00:   slice_r = slice_a & bx;
      2'b01:   slice_r = slice_a | bx;
      default: begin
        slice_r  = slice_a ^ bx ^ slice_cin;
        slice_co = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level reference computed with plain arithmetic.
  task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output logic [W-1:0] res, output logic co,
                           output logic ov, output logic ill, output logic cin0);
    logic [W:0] s;
    res = '0; co = 1'b0; ov = 1'b0; ill = 1'b0; cin0 = 1'b0;
    case (o)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        s    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        res  = s[W-1:0];
        co   = s[W];
        ov   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        cin0 = c;
      end
      3'b110: begin
        s    = {1'b0, a} + {1'b0, ~b} + 1;
        res  = a - b;
        co   = s[W];
        ov   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        cin0 = 1'b1;
      end
      3'b111: begin
        res  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        cin0 = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/result"}, result, 0);
    chk({tag, "/carry_out"}, carry_out, 0);
    chk({tag, "/overflow"}, overflow, 0);
    chk({tag, "/illegal"}, illegal, 0);
    chk({tag, "/zero"}, zero, 0);
    chk({tag, "/slices"}, {slice_a, slice_b, slice_add_sub, slice_cin, slice_op}, 0);
  endtask

  // Issue one op; optionally hold a competing OR request while busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input bit noise);
    logic [W-1:0] er, sa, sb;
    logic eco, eov, eill, ecin0, ez, cin0;
    int n;
    ref_model(o, a, b, c, er, eco, eov, eill, ecin0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ez = (er == '0);
`else
    ez = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; carry_in = c;
    @(posedge clk); #1;
    chk({tag, "/busy_first"}, busy, 1);
    sa = '0; sb = '0;
    sa[0] = slice_a; sb[0] = slice_b; cin0 = slice_cin;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = noise; op = 3'b001;
      opa = W'($urandom); opb = W'($urandom); carry_in = 1'($urandom);
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
      if (i < W) begin
        sa[i] = slice_a;
        sb[i] = slice_b;
      end
    end
    start = 1'b0;
    chk({tag, "/latency"}, n, W + 1);
    chk({tag, "/result"}, result, er);
    chk({tag, "/carry_out"}, carry_out, eco);
    chk({tag, "/overflow"}, overflow, eov);
    chk({tag, "/illegal"}, illegal, eill);
    chk({tag, "/zero"}, zero, ez);
    chk({tag, "/busy_done"}, busy, 0);
    chk({tag, "/slice_a_bits"}, sa, eill ? '0 : a);
    chk({tag, "/slice_b_bits"}, sb, eill ? '0 : b);
    chk({tag, "/slice_cin0"}, cin0, eill ? 1'b0 : ecin0);
    @(posedge clk); #1;
    chk({tag, "/done_once"}, done, 0);
    chk({tag, "/result_hold"}, result, er);
    chk({tag, "/slices_idle"}, {slice_a, slice_b, slice_add_sub, slice_cin, slice_op}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; opa = '0; opb = '0; carry_in = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("add_ovf",  3'b010, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("add_cin",  3'b010, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_op("sub",      3'b110, 8'h05, 8'h07, 1'b0, 1'b0);
    run_op("slt_1",    3'b111, 8'hFE, 8'h03, 1'b0, 1'b0);
    run_op("slt_0",    3'b111, 8'h03, 8'hFE, 1'b0, 1'b0);
    run_op("slt_ovf",  3'b111, 8'h80, 8'h01, 1'b0, 1'b0);
    run_op("and",      3'b000, 8'hF0, 8'h3C, 1'b0, 1'b0);
    run_op("or",       3'b001, 8'hF0, 8'h3C, 1'b0, 1'b0);
    run_op("and_zero", 3'b000, 8'h0F, 8'hF0, 1'b0, 1'b0);
    run_op("sub_zero", 3'b110, 8'h5A, 8'h5A, 1'b0, 1'b0);
    run_op("add_busy_start", 3'b010, 8'h12, 8'h34, 1'b1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      run_op("rand", 3'($urandom), W'($urandom), W'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    // Abort a SUB mid-shift with an asynchronous reset.
    run_op("pre_abort", 3'b110, 8'h05, 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'b110; opa = 8'h33; opb = 8'h11; carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort/no_done", dcnt, 0);
    run_op("illegal_101", 3'b101, 8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op("illegal_011", 3'b011, 8'hFF, 8'hFF, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
